// File: rtl/fib_lookup_engine.sv
// fib_lookup_engine: per-packet destination lookup in a direct-mapped FIB,
// source MAC learning, page refcount update and a background aging sweep.
//
// state  | meaning
// INIT   | clearing the table, one entry per cycle
// IDLE   | waiting for a header record or a pending aging step
// DA_DEC | table data back; decide destinations and offer them downstream
// LEARN  | write the source MAC entry with a fresh age
// REFUP  | offer the page refcount update; ack the header on acceptance
// AGE_WR | decrement one entry's age (no write if already expired)
module fib_lookup_engine #(
  parameter int NUM_PORTS = 4,
  parameter int PORT_W    = 2,
  parameter int FIB_ASZ   = 8,
  parameter int AGE_W     = 2,
  parameter int MAX_AGE   = 3,
  parameter int PG_ASZ    = 8,
  parameter int REF_W     = 3
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         lpp_srdy,
  output logic                         lpp_drdy,
  input  logic [47:0]                  lpp_macda,
  input  logic [47:0]                  lpp_macsa,
  input  logic [PORT_W-1:0]            lpp_srcport,
  input  logic [PG_ASZ-1:0]            lpp_startpg,
  output logic [FIB_ASZ-1:0]           ft_addr,
  output logic                         ft_rd_en,
  output logic                         ft_wr_en,
  output logic [48+PORT_W+AGE_W-1:0]   ft_wdata,
  input  logic [48+PORT_W+AGE_W-1:0]   ft_rdata,
  output logic                         lout_srdy,
  input  logic                         lout_drdy,
  output logic [PG_ASZ-1:0]            lout_start,
  output logic [NUM_PORTS-1:0]         lout_dst_vld,
  output logic                         refup_srdy,
  input  logic                         refup_drdy,
  output logic [PG_ASZ-1:0]            refup_page,
  output logic [REF_W-1:0]             refup_count,
  input  logic                         age_tick,
  output logic                         init_done
);

  localparam int ENT_W = 48 + PORT_W + AGE_W;
  localparam logic [FIB_ASZ-1:0] ADDR_LAST = '1;

  typedef enum logic [2:0] {
    S_INIT,
    S_IDLE,
    S_DA_DEC,
    S_LEARN,
    S_REFUP,
    S_AGE_WR
  } state_t;

  state_t state, state_nxt;

  logic [FIB_ASZ-1:0]   init_ptr;
  logic [FIB_ASZ-1:0]   age_ptr;
  logic                 age_pend;
  logic                 age_again;
  logic [REF_W-1:0]     cnt_q;
  logic [NUM_PORTS-1:0] mask_q;
  logic                 mask_held;

  logic [47:0]          rd_mac;
  logic [PORT_W-1:0]    rd_port;
  logic [AGE_W-1:0]     rd_age;
  logic [NUM_PORTS-1:0] src_oh;
  logic [NUM_PORTS-1:0] flood_mask;
  logic [NUM_PORTS-1:0] dec_mask_raw;
  logic [NUM_PORTS-1:0] dec_mask;
  logic                 da_hit;
  logic                 tick_ok;
  logic                 sweep_last;

  // XOR-fold of the MAC into FIB_ASZ-bit slices; bit i lands in slice bit i mod FIB_ASZ
  function automatic logic [FIB_ASZ-1:0] fib_hash(input logic [47:0] mac);
    logic [FIB_ASZ-1:0] h;
    h = '0;
    for (int i = 0; i < 48; i++) begin
      h[i % FIB_ASZ] = h[i % FIB_ASZ] ^ mac[i];
    end
    return h;
  endfunction

  // port indices beyond NUM_PORTS-1 decode to an empty mask
  function automatic logic [NUM_PORTS-1:0] port_onehot(input logic [PORT_W-1:0] p);
    logic [NUM_PORTS-1:0] oh;
    for (int i = 0; i < NUM_PORTS; i++) begin
      oh[i] = (p == PORT_W'(i));
    end
    return oh;
  endfunction

  function automatic logic [REF_W-1:0] popcount(input logic [NUM_PORTS-1:0] m);
    logic [REF_W-1:0] c;
    c = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      c = c + REF_W'(m[i]);
    end
    return c;
  endfunction

  assign rd_mac  = ft_rdata[ENT_W-1 -: 48];
  assign rd_port = ft_rdata[AGE_W +: PORT_W];
  assign rd_age  = ft_rdata[AGE_W-1:0];

  assign src_oh       = port_onehot(lpp_srcport);
  assign flood_mask   = ~src_oh;
  assign da_hit       = (rd_age != '0) && (rd_mac == lpp_macda);
  assign dec_mask_raw = da_hit ? (port_onehot(rd_port) & ~src_oh) : flood_mask;
  // table read data is only guaranteed for one cycle, so a stalled decision replays the capture
  assign dec_mask     = mask_held ? mask_q : dec_mask_raw;

  assign tick_ok    = age_tick && (state != S_INIT);
  assign sweep_last = (state == S_AGE_WR) && (age_ptr == ADDR_LAST);

  assign lout_start  = lpp_startpg;
  assign refup_page  = lpp_startpg;
  assign refup_count = cnt_q;

  // state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_INIT;
    else       state <= state_nxt;
  end

  // next state and all strobes, decoded from the current state
  always_comb begin
    state_nxt    = state;
    lpp_drdy     = 1'b0;
    ft_addr      = '0;
    ft_rd_en     = 1'b0;
    ft_wr_en     = 1'b0;
    ft_wdata     = '0;
    lout_srdy    = 1'b0;
    lout_dst_vld = '0;
    refup_srdy   = 1'b0;
    case (state)
      S_INIT: begin
        ft_wr_en = 1'b1;
        ft_addr  = init_ptr;
        if (init_ptr == ADDR_LAST) state_nxt = S_IDLE;
      end
      S_IDLE: begin
        if (lpp_srdy) begin
          if (lpp_macda[40]) begin
            lout_srdy    = 1'b1;
            lout_dst_vld = flood_mask;
            if (lout_drdy) state_nxt = S_LEARN;
          end else begin
            ft_rd_en  = 1'b1;
            ft_addr   = fib_hash(lpp_macda);
            state_nxt = S_DA_DEC;
          end
        end else if (age_pend) begin
          ft_rd_en  = 1'b1;
          ft_addr   = age_ptr;
          state_nxt = S_AGE_WR;
        end
      end
      S_DA_DEC: begin
        if (dec_mask != '0) begin
          lout_srdy    = 1'b1;
          lout_dst_vld = dec_mask;
          if (lout_drdy) state_nxt = S_LEARN;
        end else begin
          state_nxt = S_LEARN;
        end
      end
      S_LEARN: begin
        ft_wr_en  = 1'b1;
        ft_addr   = fib_hash(lpp_macsa);
        ft_wdata  = {lpp_macsa, lpp_srcport, AGE_W'(MAX_AGE)};
        state_nxt = S_REFUP;
      end
      S_REFUP: begin
        refup_srdy = 1'b1;
        if (refup_drdy) begin
          lpp_drdy  = 1'b1;
          state_nxt = S_IDLE;
        end
      end
      S_AGE_WR: begin
        if (rd_age != '0) begin
          ft_wr_en = 1'b1;
          ft_addr  = age_ptr;
          ft_wdata = {rd_mac, rd_port, rd_age - AGE_W'(1)};
        end
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_INIT;
    endcase
  end

  // init sweep pointer and the sticky init_done flag
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      init_ptr  <= '0;
      init_done <= 1'b0;
    end else if (state == S_INIT) begin
      init_ptr <= init_ptr + FIB_ASZ'(1);
      if (init_ptr == ADDR_LAST) init_done <= 1'b1;
    end
  end

  // aging: pointer walk, pending sweep and one remembered re-request
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      age_ptr   <= '0;
      age_pend  <= 1'b0;
      age_again <= 1'b0;
    end else begin
      if (state == S_AGE_WR) age_ptr <= age_ptr + FIB_ASZ'(1);
      if (sweep_last) begin
        age_pend  <= age_again | tick_ok;
        age_again <= 1'b0;
      end else if (tick_ok) begin
        if (age_pend) age_again <= 1'b1;
        else          age_pend  <= 1'b1;
      end
    end
  end

  // destination count for the refcount update, and the held decision mask
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q     <= '0;
      mask_q    <= '0;
      mask_held <= 1'b0;
    end else begin
      if (lout_srdy && lout_drdy)                  cnt_q <= popcount(lout_dst_vld);
      else if (state == S_DA_DEC && dec_mask == '0) cnt_q <= '0;
      if (state == S_DA_DEC && !mask_held) mask_q <= dec_mask_raw;
      mask_held <= (state == S_DA_DEC) && (state_nxt == S_DA_DEC);
    end
  end

endmodule
